mem_wb_stage: RTL and testbench

- Memory stage plus MEM/WB pipeline register of the 5-stage MIPS core.
- Consumes the EX/MEM register outputs and runs loads/stores against a variable-latency data memory using a req/ready handshake.
- Stalls the upstream pipeline while an access is outstanding, then presents write-back fields to the WB stage.
- Flags misaligned word accesses and memory timeouts.

---
 rtl/mem_if.sv | 19 +
 rtl/mem_wb_stage.sv | 138 +++++++++++++
 tb/tb_mem_wb_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the memory (slave).
interface mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS memory stage plus MEM/WB register: runs loads/stores over a variable-latency
// req/ready bus, stalls upstream while waiting, flags misalignment and timeouts.
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteDataMEM,
  input  logic [4:0]  WriteRegMEM,
  input  logic        RegWriteMEM,
  input  logic        MemReadMEM,
  input  logic        MemWriteMEM,
  input  logic        MemtoRegMEM,
  output logic        stall,
  mem_if.master       mem,
  output logic [31:0] ReadDataWB,
  output logic [31:0] ALUResultWB,
  output logic [4:0]  WriteRegWB,
  output logic        RegWriteWB,
  output logic        MemtoRegWB,
  output logic        misaligned_err,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [31:0]      rdata_q, alu_q;
  logic [4:0]       wreg_q;
  logic             rw_q, m2r_q, misal_q, bus_q;

  logic access, aligned, timeout;

  always_comb begin
    access  = MemReadMEM | MemWriteMEM;
    aligned = (Address[1:0] == 2'b00);
    timeout = (cnt_q == CNT_LAST) && !mem.mem_ready;
    cnt_d   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
  end

  // Gated by reset so an abort mid-WAIT releases the pipeline before the next edge.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE:  stall = access && aligned;
        S_WAIT:  stall = !mem.mem_ready && !timeout;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      misal_q <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      misal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!access) begin
            alu_q  <= Address;
            wreg_q <= WriteRegMEM;
            rw_q   <= RegWriteMEM;
            m2r_q  <= MemtoRegMEM;
          end else begin
            rw_q  <= 1'b0;
            m2r_q <= 1'b0;
            if (!aligned) begin
              misal_q <= 1'b1;
            end else begin
              addr_q  <= Address;
              wdata_q <= WriteDataMEM;
              we_q    <= MemWriteMEM;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (mem.mem_ready) begin
            if (MemReadMEM) rdata_q <= mem.mem_rdata;
            alu_q   <= Address;
            wreg_q  <= WriteRegMEM;
            rw_q    <= RegWriteMEM;
            m2r_q   <= MemtoRegMEM;
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (timeout) begin
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            req_q   <= 1'b0;
            bus_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            rw_q  <= 1'b0;
            m2r_q <= 1'b0;
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req    = req_q;
  assign mem.mem_we     = we_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_wdata  = wdata_q;
  assign ReadDataWB     = rdata_q;
  assign ALUResultWB    = alu_q;
  assign WriteRegWB     = wreg_q;
  assign RegWriteWB     = rw_q;
  assign MemtoRegWB     = m2r_q;
  assign misaligned_err = misal_q;
  assign bus_error      = bus_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteDataMEM;
  logic [4:0]  WriteRegMEM;
  logic        RegWriteMEM, MemReadMEM, MemWriteMEM, MemtoRegMEM;
  logic        stall;
  logic [31:0] ReadDataWB, ALUResultWB;
  logic [4:0]  WriteRegWB;
  logic        RegWriteWB, MemtoRegWB, misaligned_err, bus_error;

  mem_if bus ();

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Address(Address), .WriteDataMEM(WriteDataMEM), .WriteRegMEM(WriteRegMEM),
    .RegWriteMEM(RegWriteMEM), .MemReadMEM(MemReadMEM), .MemWriteMEM(MemWriteMEM),
    .MemtoRegMEM(MemtoRegMEM), .stall(stall), .mem(bus.master),
    .ReadDataWB(ReadDataWB), .ALUResultWB(ALUResultWB), .WriteRegWB(WriteRegWB),
    .RegWriteWB(RegWriteWB), .MemtoRegWB(MemtoRegWB),
    .misaligned_err(misaligned_err), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Architectural view of the MEM/WB register and sticky error.
  logic [31:0] m_rdata, m_alu;
  logic [4:0]  m_wreg;
  logic        m_rw, m_m2r, m_bus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = '0; m_alu = '0; m_wreg = '0; m_rw = 1'b0; m_m2r = 1'b0; m_bus = 1'b0;
  endtask

  // Present one EX/MEM instruction at a negedge; memory answers after lat WAIT cycles.
  task automatic do_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic ld, input logic st, input int lat);
    int stall_cnt = 0, req_cnt = 0, seen = 0, exp_stall = 0, exp_req = 0;
    logic s, r, stable_ok = 1'b1, exp_mis = 1'b0, full = 1'b0;
    logic [31:0] got = '0;
    Address = addr; WriteDataMEM = wd; WriteRegMEM = rd; RegWriteMEM = rw;
    MemtoRegMEM = m2r; MemReadMEM = ld; MemWriteMEM = st;
    for (int cyc = 0; cyc < 64; cyc++) begin
      bus.mem_rdata = $urandom;
      r = bus.mem_req;
      if (r === 1'b1) bus.mem_ready = (seen == lat);
      else            bus.mem_ready = 1'($urandom_range(0, 1));
      if (r === 1'b1 && bus.mem_ready) got = bus.mem_rdata;
      #1;
      s = stall;
      if (s === 1'b1) stall_cnt++;
      if (r === 1'b1) begin
        req_cnt++;
        if (bus.mem_addr !== addr || bus.mem_wdata !== wd || bus.mem_we !== st) stable_ok = 1'b0;
      end
      @(posedge clk);
      if (r === 1'b1) seen++;
      @(negedge clk);
      if (s !== 1'b1) break;
    end
    bus.mem_ready = 1'b0;

    if (!(ld || st)) begin
      m_alu = addr; m_wreg = rd; m_rw = rw; m_m2r = m2r; full = 1'b1;
    end else if (addr[1:0] != 2'b00) begin
      m_rw = 1'b0; m_m2r = 1'b0; exp_mis = 1'b1;
    end else if (lat < TIMEOUT) begin
      exp_stall = lat + 1; exp_req = lat + 1;
      m_alu = addr; m_wreg = rd; m_rw = rw; m_m2r = m2r; full = 1'b1;
      if (ld) m_rdata = got;
    end else begin
      exp_stall = TIMEOUT; exp_req = TIMEOUT;
      m_rw = 1'b0; m_m2r = 1'b0; m_bus = 1'b1;
    end

    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, ".req_cycles"}, 32'(req_cnt), 32'(exp_req));
    chk({tag, ".bus_stable"}, {31'b0, stable_ok}, 32'd1);
    chk({tag, ".req_after"}, {31'b0, bus.mem_req}, 32'd0);
    chk({tag, ".misaligned"}, {31'b0, misaligned_err}, {31'b0, exp_mis});
    chk({tag, ".bus_error"}, {31'b0, bus_error}, {31'b0, m_bus});
    chk({tag, ".RegWriteWB"}, {31'b0, RegWriteWB}, {31'b0, m_rw});
    chk({tag, ".MemtoRegWB"}, {31'b0, MemtoRegWB}, {31'b0, m_m2r});
    chk({tag, ".ReadDataWB"}, ReadDataWB, m_rdata);
    if (full) begin
      chk({tag, ".ALUResultWB"}, ALUResultWB, m_alu);
      chk({tag, ".WriteRegWB"}, {27'b0, WriteRegWB}, {27'b0, m_wreg});
    end
  endtask

  initial begin
    int kind, lat;
    logic [31:0] a;
    reset = 1'b1;
    Address = '0; WriteDataMEM = '0; WriteRegMEM = '0; RegWriteMEM = 1'b0;
    MemReadMEM = 1'b0; MemWriteMEM = 1'b0; MemtoRegMEM = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst.stall", {31'b0, stall}, 32'd0);
    chk("rst.ALUResultWB", ALUResultWB, 32'd0);
    chk("rst.ReadDataWB", ReadDataWB, 32'd0);
    chk("rst.RegWriteWB", {31'b0, RegWriteWB}, 32'd0);
    chk("rst.bus_error", {31'b0, bus_error}, 32'd0);
    reset = 1'b0;

    do_op("alu",      32'h0000_0040, 32'h0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_op("load0",    32'h0000_0100, 32'h0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 0);
    do_op("store3",   32'h0000_0204, 32'h1234_5678, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    do_op("misal",    32'h0000_0102, 32'h0, 5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 0);
    do_op("alu2",     32'h0000_0ABC, 32'h0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_op("edge_ld",  32'h0000_0300, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, TIMEOUT - 1);
    do_op("timeout",  32'h0000_0400, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, TIMEOUT);
    do_op("after_to", 32'h0000_0044, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(0, TIMEOUT + 1));
      a    = $urandom;
      case (kind)
        0: do_op("rnd_alu", a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 0);
        1: do_op("rnd_ld", {a[31:2], 2'b00}, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, lat);
        2: do_op("rnd_st", {a[31:2], 2'b00}, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, lat);
        default: do_op("rnd_mis", {a[31:2], 2'(1 + $urandom_range(0, 2))}, $urandom,
                       5'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'b1, 0);
      endcase
    end

    // Async reset in the middle of a pending load.
    Address = 32'h0000_0500; WriteRegMEM = 5'd6; RegWriteMEM = 1'b1; MemtoRegMEM = 1'b1;
    MemReadMEM = 1'b1; MemWriteMEM = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst.mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("arst.stall", {31'b0, stall}, 32'd0);
    chk("arst.ReadDataWB", ReadDataWB, 32'd0);
    chk("arst.ALUResultWB", ALUResultWB, 32'd0);
    chk("arst.WriteRegWB", {27'b0, WriteRegWB}, 32'd0);
    chk("arst.RegWriteWB", {31'b0, RegWriteWB}, 32'd0);
    chk("arst.MemtoRegWB", {31'b0, MemtoRegWB}, 32'd0);
    chk("arst.bus_error", {31'b0, bus_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_op("post_rst", 32'h0000_0048, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
